// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-back front end.
// Entry and write-port layouts used by rf_wb_queue and rf_write_arbiter.
package rf_wb_pkg;

   localparam int REG_W     = 8;
   localparam int REG_IDX_W = 3;

   typedef struct packed {
      logic                 live;
      logic [REG_IDX_W-1:0] rd;
      logic [REG_W-1:0]     data;
   } wb_entry_t;

   typedef struct packed {
      logic                 we;
      logic [REG_IDX_W-1:0] rd;
      logic [REG_W-1:0]     data;
   } wb_port_t;

endpackage

// File: rtl/rf_wb_queue.sv
// In-order load-result queue with kill-by-rd broadcast.
// With WB_QUERY_EN defined it also reports whether a live entry targets query_rs.
module rf_wb_queue
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 push,
   input  logic [REG_IDX_W-1:0] push_rd,
   input  logic [REG_W-1:0]     push_data,
   input  logic                 pop,
   input  logic                 kill_valid,
   input  logic [REG_IDX_W-1:0] kill_rd,
   output logic                 head_live,
   output logic [REG_IDX_W-1:0] head_rd,
   output logic [REG_W-1:0]     head_data,
   output logic                 empty,
   output logic                 full
`ifdef WB_QUERY_EN
   ,
   input  logic [REG_IDX_W-1:0] query_rs,
   output logic                 query_hit
`endif
);

   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   wb_entry_t     mem [DEPTH];
   wb_entry_t     push_entry;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   // A load accepted alongside an ALU write to the same register is older, so it lands dead.
   always_comb begin
      push_entry      = '0;
      push_entry.live = !(kill_valid && (push_rd == kill_rd));
      push_entry.rd   = push_rd;
      push_entry.data = push_data;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (kill_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (mem[i].rd == kill_rd) mem[i].live <= 1'b0;
            end
         end
         // Clearing live on pop keeps every unoccupied slot dead, so the query needs no occupancy mask.
         if (pop) begin
            mem[rd_ptr].live <= 1'b0;
            rd_ptr           <= rd_ptr + AW'(1);
         end
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_live = mem[rd_ptr].live;
   assign head_rd   = mem[rd_ptr].rd;
   assign head_data = mem[rd_ptr].data;
   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);

`ifdef WB_QUERY_EN
   always_comb begin
      query_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i].live && (mem[i].rd == query_rs)) query_hit = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges ALU and load results onto the register file's single write port.
// Optional WB_QUERY_EN exposes query_rs/query_hit for pending-load lookups.
module rf_write_arbiter
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       alu_valid,
   input  logic [2:0] alu_rd,
   input  logic [7:0] alu_data,
   input  logic       ld_valid,
   input  logic [2:0] ld_rd,
   input  logic [7:0] ld_data,
   output logic       ld_ready,
   output logic       regWrite,
   output logic [2:0] Rd,
   output logic [7:0] writeValue
`ifdef WB_QUERY_EN
   ,
   input  logic [2:0] query_rs,
   output logic       query_hit
`endif
);

   wb_port_t             wb;
   logic                 pop;
   logic                 bypass;
   logic                 push;
   logic                 q_empty;
   logic                 q_full;
   logic                 head_live;
   logic [REG_IDX_W-1:0] head_rd;
   logic [REG_W-1:0]     head_data;

   // Load handshake: a load transfers on ld_valid && ld_ready (bypass only happens
   // when the queue is empty, where ld_ready is already 1); the producer holds
   // ld_valid/ld_rd/ld_data stable until then. ld_ready depends on registered state only.
   assign ld_ready = !q_full;

   // Priority: ALU, then queue head, then bypass of a load into an empty queue.
   always_comb begin
      wb     = '0;
      pop    = 1'b0;
      bypass = 1'b0;
      if (alu_valid) begin
         wb.we   = 1'b1;
         wb.rd   = alu_rd;
         wb.data = alu_data;
      end else if (!q_empty) begin
         pop = 1'b1;
         if (head_live) begin
            wb.we   = 1'b1;
            wb.rd   = head_rd;
            wb.data = head_data;
         end
      end else if (ld_valid) begin
         bypass  = 1'b1;
         wb.we   = 1'b1;
         wb.rd   = ld_rd;
         wb.data = ld_data;
      end
      if (!RST_N) wb = '0;
   end

   assign push       = ld_valid && ld_ready && !bypass;
   assign regWrite   = wb.we;
   assign Rd         = wb.rd;
   assign writeValue = wb.data;

   rf_wb_queue #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_queue (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .push       (push),
      .push_rd    (ld_rd),
      .push_data  (ld_data),
      .pop        (pop),
      .kill_valid (alu_valid),
      .kill_rd    (alu_rd),
      .head_live  (head_live),
      .head_rd    (head_rd),
      .head_data  (head_data),
      .empty      (q_empty),
      .full       (q_full)
`ifdef WB_QUERY_EN
      ,
      .query_rs   (query_rs),
      .query_hit  (query_hit)
`endif
   );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: write-port stream scoreboard plus per-cycle handshake checks.
module tb_rf_write_arbiter;

   logic       CLK;
   logic       RST_N;
   logic       alu_valid;
   logic [2:0] alu_rd;
   logic [7:0] alu_data;
   logic       ld_valid;
   logic [2:0] ld_rd;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic       regWrite;
   logic [2:0] Rd;
   logic [7:0] writeValue;
`ifdef WB_QUERY_EN
   logic [2:0] query_rs;
   logic       query_hit;
`endif

   int checks   = 0;
   int failures = 0;
   logic [10:0] exp_q[$];

   rf_write_arbiter #(
      .DEPTH (4),
      .AW    (2)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .ld_valid   (ld_valid),
      .ld_rd      (ld_rd),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .regWrite   (regWrite),
      .Rd         (Rd),
      .writeValue (writeValue)
`ifdef WB_QUERY_EN
      ,
      .query_rs   (query_rs),
      .query_hit  (query_hit)
`endif
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // driver tasks
   task automatic drive(input logic av, input logic [2:0] ar, input logic [7:0] ad,
                        input logic lv, input logic [2:0] lr, input logic [7:0] ldat);
      alu_valid = av;
      alu_rd    = ar;
      alu_data  = ad;
      ld_valid  = lv;
      ld_rd     = lr;
      ld_data   = ldat;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic next();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_wr(input logic [2:0] rd, input logic [7:0] data);
      exp_q.push_back({rd, data});
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input string tag, input logic exp_we, input logic exp_rdy);
      @(negedge CLK);
      chk1({tag, "_we"}, regWrite, exp_we);
      chk1({tag, "_rdy"}, ld_ready, exp_rdy);
   endtask

   // scoreboard: every committed write must be the next expected {rd, data}
   always @(negedge CLK) begin
      logic [10:0] want;
      if (RST_N && regWrite) begin
         want = (exp_q.size() != 0) ? exp_q.pop_front() : 11'bx;
         checks++;
         assert ({Rd, writeValue} === want) else begin
            failures++;
            $error("FAIL wb_stream observed=%h expected=%h", {Rd, writeValue}, want);
         end
      end
   end

   initial begin
      logic [2:0] lr;
      logic [7:0] ldat;
      RST_N = 1'b0;
`ifdef WB_QUERY_EN
      query_rs = 3'd0;
`endif
      // ALU request held during reset must not reach the port
      drive(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
      #2;
      chk1("rst_we", regWrite, 1'b0);
      chk32("rst_rd", 32'(Rd), 32'd0);
      chk32("rst_wv", 32'(writeValue), 32'd0);
      chk1("rst_rdy", ld_ready, 1'b1);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      idle();

      // ALU only
      expect_wr(3'd3, 8'h5A);
      drive(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
      sample("alu_only", 1'b1, 1'b1);
      next();
      idle();
      sample("alu_idle", 1'b0, 1'b1);
      next();

      // bypass into empty queue
      expect_wr(3'd2, 8'h11);
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h11);
      sample("bypass", 1'b1, 1'b1);
      next();
      idle();
      sample("bypass_nopush", 1'b0, 1'b1);
      next();

      // contention: 5 ALU cycles, loads r1..r4 queue, r7 waits for a slot
      for (int k = 0; k < 5; k++) expect_wr(3'd0, 8'(128 + k));
      for (int k = 1; k < 5; k++) expect_wr(3'(k), 8'(k));
      expect_wr(3'd7, 8'h07);
      for (int k = 0; k < 5; k++) begin
         lr   = (k < 4) ? 3'(k + 1) : 3'd7;
         ldat = (k < 4) ? 8'(k + 1) : 8'h07;
         drive(1'b1, 3'd0, 8'(128 + k), 1'b1, lr, ldat);
         sample($sformatf("cont%0d", k), 1'b1, (k < 4));
         next();
      end
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h07);
      sample("full_pop", 1'b1, 1'b0);
      next();
      sample("drain_r2", 1'b1, 1'b1);
      next();
      idle();
      for (int k = 0; k < 3; k++) begin
         sample($sformatf("drain%0d", k + 3), 1'b1, 1'b1);
         next();
      end
      sample("drain_done", 1'b0, 1'b1);
      next();

      // kill of a queued load by a newer ALU write
      expect_wr(3'd0, 8'h33);
      drive(1'b1, 3'd0, 8'h33, 1'b1, 3'd5, 8'hAA);
      sample("kill_setup", 1'b1, 1'b1);
      next();
      expect_wr(3'd5, 8'h77);
      drive(1'b1, 3'd5, 8'h77, 1'b0, 3'd0, 8'h00);
      sample("kill_alu", 1'b1, 1'b1);
`ifdef WB_QUERY_EN
      query_rs = 3'd5;
      #1;
      chk1("query_live", query_hit, 1'b1);
`endif
      next();
      idle();
      sample("kill_pop_dead", 1'b0, 1'b1);
`ifdef WB_QUERY_EN
      chk1("query_after_kill", query_hit, 1'b0);
`endif
      next();
      sample("kill_empty", 1'b0, 1'b1);
      next();

      // same-cycle kill: load to r6 pushed dead behind a live r3
      expect_wr(3'd0, 8'h44);
      drive(1'b1, 3'd0, 8'h44, 1'b1, 3'd3, 8'h3C);
      sample("sc_setup", 1'b1, 1'b1);
      next();
      expect_wr(3'd6, 8'h66);
      drive(1'b1, 3'd6, 8'h66, 1'b1, 3'd6, 8'hE6);
      sample("sc_kill", 1'b1, 1'b1);
      next();
      expect_wr(3'd3, 8'h3C);
      idle();
      sample("sc_pop_r3", 1'b1, 1'b1);
`ifdef WB_QUERY_EN
      query_rs = 3'd6;
      #1;
      chk1("query_dead_push", query_hit, 1'b0);
`endif
      next();
      sample("sc_pop_dead", 1'b0, 1'b1);
      next();
      sample("sc_empty", 1'b0, 1'b1);
      next();

      // asynchronous reset while draining with 3 entries queued
      for (int k = 0; k < 4; k++) begin
         expect_wr(3'd0, 8'(16 + k));
         drive(1'b1, 3'd0, 8'(16 + k), 1'b1, 3'(k + 1), 8'(33 + k));
         sample($sformatf("rst_fill%0d", k), 1'b1, 1'b1);
         next();
      end
      expect_wr(3'd1, 8'h21);
      idle();
      sample("rst_drain1", 1'b1, 1'b0);
      next();
      chk1("rst_pre_we", regWrite, 1'b1);
`ifdef WB_QUERY_EN
      query_rs = 3'd2;
`endif
      #1;
      RST_N = 1'b0;
      #1;
      chk1("rst_mid_we", regWrite, 1'b0);
      chk1("rst_mid_rdy", ld_ready, 1'b1);
      chk32("rst_mid_rd", 32'(Rd), 32'd0);
      chk32("rst_mid_wv", 32'(writeValue), 32'd0);
`ifdef WB_QUERY_EN
      chk1("rst_mid_query", query_hit, 1'b0);
`endif
      next();
      RST_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sample($sformatf("post_rst%0d", k), 1'b0, 1'b1);
         next();
      end

      chk32("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-side front end for the 8-entry, 8-bit CPU register file. It merges two result sources into the register file's single synchronous write port: a single-cycle ALU result and a variable-latency load result. Load results that lose arbitration are buffered in a small in-order queue. When a newer ALU write targets the same register, any queued load to that register is killed so the ALU value is not overwritten.

## Interface
Parameters:
- DEPTH, 4, load-queue entries (power of two, ≥2)
- AW, 2, log2(DEPTH)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  reset; asynchronous, active-low
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  3  ALU destination register
- alu_data  in  8  ALU result
- ld_valid  in  1  load result offered
- ld_rd  in  3  load destination register
- ld_data  in  8  load result
- ld_ready  out  1  queue can accept a load this cycle
- regWrite  out  1  register file write enable
- Rd  out  3  register file write index
- writeValue  out  8  register file write data
- query_rs  in  3  register index to check for a pending load (WB_QUERY_EN only)
- query_hit  out  1  a live queued load targets query_rs (WB_QUERY_EN only)

## Operation
- Entry fields: live, rd[2:0], data[7:0]. Occupancy counter runs 0..DEPTH. Read and write pointers are AW bits and wrap modulo DEPTH.
- ld_ready = (count < DEPTH). It is computed from registered state only; a same-cycle pop does not free a slot.
- Write-port priority each cycle:
  1. alu_valid: regWrite=1, Rd=alu_rd, writeValue=alu_data.
  2. Else queue non-empty: pop head. If the head is live, regWrite=1 with the head's rd and data. If the head is killed, regWrite=0 and the slot is still consumed.
  3. Else ld_valid with queue empty: bypass directly, regWrite=1, Rd=ld_rd, writeValue=ld_data. Nothing is pushed.
  4. Else regWrite=0, Rd=0, writeValue=0.
- Push: when ld_valid && ld_ready and the load is not bypassed (case 3), write the entry at the write pointer with live=1.
- Kill: when alu_valid, every queued entry with rd==alu_rd has live cleared at the edge. A load pushed in the same cycle with ld_rd==alu_rd is written with live=0. Same-cycle loads are defined as older than the ALU result.
- Killed entries are never written to the register file. Order among surviving loads is preserved.
- query_hit: OR over occupied entries of (live && rd==query_rs). It is combinational and does not include an in-flight ld_valid.

## Timing
- Write-port outputs are combinational from inputs and registered queue state. The register file samples them at the next posedge.
- Latency: ALU to regWrite is 0 cycles. A bypassed load is 0 cycles. A queued load is written in the first cycle with no alu_valid after all older entries have drained.
- Throughput: one register-file write per cycle.
- Sustained alu_valid starves the queue indefinitely. This is legal; the load unit must hold ld_valid/ld_rd/ld_data stable until ld_ready.
- Full queue with a pop: ld_ready stays 0 that cycle and is 1 the next cycle.
- Reset (RST_N low, at any time including mid-drain):
  - count=0, pointers=0, all live=0.
  - regWrite forced 0 while RST_N is low; Rd=0, writeValue=0.
  - ld_ready=1, query_hit=0.
- First write after release is possible in the cycle following the first posedge.

## Configuration
- WB_QUERY_EN defined: query_rs/query_hit ports and the comparator logic are present.
- Undefined: both ports are absent; queue behaviour is otherwise identical.

## Structure
- Package rf_wb_pkg holds:
  - REG_W=8, REG_IDX_W=3
  - wb_entry_t packed struct {live, rd, data}
  - the write-port output struct
- Sub-module rf_wb_queue holds the entry storage, pointers, counter, kill-by-rd broadcast and the query match. The top level owns arbitration and bypass.

## Test plan
- ALU only: alu_valid, rd=3, data=0x5A → same cycle regWrite=1, Rd=3, writeValue=0x5A; queue stays empty.
- Bypass: queue empty, ld_valid rd=2 data=0x11 → regWrite=1, Rd=2, writeValue=0x11; count stays 0.
- Contention then drain:
  - Stimulus: alu_valid for 5 cycles plus loads to r1..r4 (0x01..0x04).
  - During the ALU cycles: ld_ready=0 after 4 pushes.
  - Then: r1..r4 are written in order over 4 cycles.
- Kill: queue holds a load r5=0xAA, then alu_valid r5=0x77 → 0x77 written; the later pop of r5 has regWrite=0; query_hit(r5)=0 after the kill.
- Same-cycle kill: ld_valid r6 and alu_valid r6 while the queue is non-empty → entry pushed dead; r6 ends at the ALU value.
- Async reset mid-drain with 3 entries queued → regWrite=0 immediately, ld_ready=1; no stale write after release.
